// File: rtl/npu_tile_scheduler_if.sv
// Handshake bundle between the tile scheduler and its user/engine surroundings.
// perf_cycles exists only when TILE_SCHED_PERF_EN is defined.
interface npu_tile_scheduler_if #(
    parameter int ADDR_W = 18
) ();
    // Each request (load_req, wb_req) rises alone and stays high until its ack
    // is sampled high; an ack seen while the request is low means nothing.
    // npu_start is a one-cycle pulse; npu_done is a level the NPU holds until wb_req.
    logic              start_pulse;
    logic              step_pulse;
    logic              abort;
    logic              load_req;
    logic              load_ack;
    logic              npu_start;
    logic              npu_done;
    logic              wb_req;
    logic              wb_ack;
    logic [ADDR_W-1:0] tile_base_addr;
    logic [5:0]        tile_x;
    logic [5:0]        tile_y;
    logic [11:0]       tiles_done;
    logic              busy;
    logic              step_wait;
    logic              done;
    logic [2:0]        dbg_state;
`ifdef TILE_SCHED_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    modport master (
        input  start_pulse, step_pulse, abort, load_ack, npu_done, wb_ack,
        output load_req, npu_start, wb_req, tile_base_addr, tile_x, tile_y,
               tiles_done, busy, step_wait, done, dbg_state
`ifdef TILE_SCHED_PERF_EN
        , output perf_cycles
`endif
    );

    modport slave (
        output start_pulse, step_pulse, abort, load_ack, npu_done, wb_ack,
        input  load_req, npu_start, wb_req, tile_base_addr, tile_x, tile_y,
               tiles_done, busy, step_wait, done, dbg_state
`ifdef TILE_SCHED_PERF_EN
        , input perf_cycles
`endif
    );
endinterface

// File: rtl/npu_tile_scheduler.sv
// Raster-order tile sequencer: load -> NPU compute -> write-back per tile, run/step/abort.
// Optional busy-cycle counter built only when TILE_SCHED_PERF_EN is defined.
module npu_tile_scheduler #(
    parameter int IMG_W  = 400,
    parameter int IMG_H  = 400,
    parameter int TILE   = 10,
    parameter int ADDR_W = 18
) (
    input logic clk,
    input logic rst,
    npu_tile_scheduler_if.master bus
);
    localparam int TX = IMG_W / TILE;
    localparam int TY = IMG_H / TILE;
    localparam logic [5:0]        LAST_X   = 6'(TX - 1);
    localparam logic [5:0]        LAST_Y   = 6'(TY - 1);
    localparam logic [ADDR_W-1:0] STEP_X   = ADDR_W'(TILE);
    // Jump from the last tile of a row to the first tile of the next row.
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(TILE * IMG_W - (TX - 1) * TILE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_WRITE   = 3'd3,
        S_ADVANCE = 3'd4,
        S_PAUSE   = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

    state_t            state_q;
    logic              run_mode_q;
    logic              load_req_q;
    logic              npu_start_q;
    logic              wb_req_q;
    logic              busy_q;
    logic              step_wait_q;
    logic              done_q;
    logic [5:0]        tile_x_q;
    logic [5:0]        tile_y_q;
    logic [11:0]       tiles_done_q;
    logic [ADDR_W-1:0] base_q;

    logic any_pulse;
    assign any_pulse = bus.start_pulse | bus.step_pulse;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            run_mode_q   <= 1'b0;
            load_req_q   <= 1'b0;
            npu_start_q  <= 1'b0;
            wb_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            step_wait_q  <= 1'b0;
            done_q       <= 1'b0;
            tile_x_q     <= '0;
            tile_y_q     <= '0;
            tiles_done_q <= '0;
            base_q       <= '0;
        end else if (bus.abort) begin
            state_q     <= S_IDLE;
            load_req_q  <= 1'b0;
            npu_start_q <= 1'b0;
            wb_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            step_wait_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_pulse) begin
                        run_mode_q   <= bus.start_pulse;
                        tile_x_q     <= '0;
                        tile_y_q     <= '0;
                        tiles_done_q <= '0;
                        base_q       <= '0;
                        done_q       <= 1'b0;
                        load_req_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.load_ack) begin
                        load_req_q  <= 1'b0;
                        npu_start_q <= 1'b1;
                        state_q     <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    // npu_start_q high marks the first cycle; npu_done is ignored there.
                    if (npu_start_q) begin
                        npu_start_q <= 1'b0;
                    end else if (bus.npu_done) begin
                        wb_req_q <= 1'b1;
                        state_q  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.wb_ack) begin
                        wb_req_q     <= 1'b0;
                        tiles_done_q <= tiles_done_q + 12'd1;
                        state_q      <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (tile_x_q == LAST_X && tile_y_q == LAST_Y) begin
                        state_q <= S_FINISH;
                    end else begin
                        if (tile_x_q == LAST_X) begin
                            tile_x_q <= '0;
                            tile_y_q <= tile_y_q + 6'd1;
                            base_q   <= base_q + ROW_STEP;
                        end else begin
                            tile_x_q <= tile_x_q + 6'd1;
                            base_q   <= base_q + STEP_X;
                        end
                        if (run_mode_q) begin
                            load_req_q <= 1'b1;
                            state_q    <= S_LOAD;
                        end else begin
                            step_wait_q <= 1'b1;
                            state_q     <= S_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (any_pulse) begin
                        if (bus.start_pulse) run_mode_q <= 1'b1;
                        step_wait_q <= 1'b0;
                        load_req_q  <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TILE_SCHED_PERF_EN
    logic [31:0] perf_q;

    // Counts active work only: neither IDLE nor time spent waiting for a step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_q <= '0;
        end else if (!bus.abort && state_q == S_IDLE && any_pulse) begin
            perf_q <= '0;
        end else if (state_q != S_IDLE && state_q != S_PAUSE && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign bus.perf_cycles = perf_q;
`endif

    assign bus.load_req       = load_req_q;
    assign bus.npu_start      = npu_start_q;
    assign bus.wb_req         = wb_req_q;
    assign bus.tile_base_addr = base_q;
    assign bus.tile_x         = tile_x_q;
    assign bus.tile_y         = tile_y_q;
    assign bus.tiles_done     = tiles_done_q;
    assign bus.busy           = busy_q;
    assign bus.step_wait      = step_wait_q;
    assign bus.done           = done_q;
    assign bus.dbg_state      = state_q;
endmodule
